cordic_iter_core: RTL and testbench

// - Iterative CORDIC (rotation mode) cosine/sine core for the DSD-CORDIC datapath.
// - Converts an IEEE-754 single-precision angle (radians) to signed fixed point,

---
 rtl/cordic_pkg.sv | 93 +++++++++
 rtl/cordic_rot_engine.sv | 41 ++++
 rtl/cordic_iter_core.sv | 140 ++++++++++++++
 tb/tb_cordic_iter_core.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Shared constants, types and helpers for the iterative CORDIC cos/sin core.
// Fixed-point format throughout is signed Q2.30.
package cordic_pkg;

    localparam int ITERS     = 32;
    localparam int W         = 32;
    localparam int FRAC_BITS = 30;

    // CORDIC gain compensation 1/prod(sqrt(1+2^-2i)) in Q2.30
    localparam logic [W-1:0] K_INIT  = 32'h26DD3B6A;
    localparam logic [W-1:0] SAT_MAG = 32'h7FFFFFFF;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    typedef struct packed {
        logic [W-1:0] value;
        logic         err;
    } unpack_t;

    // round(atan(2^-i) * 2^30); entry 31 is just below 0.5 LSB and rounds to zero
    function automatic logic [W-1:0] atan_lut(input logic [4:0] idx);
        logic [W-1:0] r;
        case (idx)
            5'd0:    r = 32'h3243F6A9;
            5'd1:    r = 32'h1DAC6705;
            5'd2:    r = 32'h0FADBAFD;
            5'd3:    r = 32'h07F56EA7;
            5'd4:    r = 32'h03FEAB77;
            5'd5:    r = 32'h01FFD55C;
            5'd6:    r = 32'h00FFFAAB;
            5'd7:    r = 32'h007FFF55;
            5'd8:    r = 32'h003FFFEB;
            5'd9:    r = 32'h001FFFFD;
            5'd10:   r = 32'h00100000;
            5'd11:   r = 32'h00080000;
            5'd12:   r = 32'h00040000;
            5'd13:   r = 32'h00020000;
            5'd14:   r = 32'h00010000;
            5'd15:   r = 32'h00008000;
            5'd16:   r = 32'h00004000;
            5'd17:   r = 32'h00002000;
            5'd18:   r = 32'h00001000;
            5'd19:   r = 32'h00000800;
            5'd20:   r = 32'h00000400;
            5'd21:   r = 32'h00000200;
            5'd22:   r = 32'h00000100;
            5'd23:   r = 32'h00000080;
            5'd24:   r = 32'h00000040;
            5'd25:   r = 32'h00000020;
            5'd26:   r = 32'h00000010;
            5'd27:   r = 32'h00000008;
            5'd28:   r = 32'h00000004;
            5'd29:   r = 32'h00000002;
            5'd30:   r = 32'h00000001;
            5'd31:   r = 32'h00000000;
            default: r = 32'h00000000;
        endcase
        return r;
    endfunction

    // float32 radians -> Q2.30; {1,m} scaled by 2^(E-120), saturating at |x| >= 2.0
    function automatic unpack_t float_to_q230(input logic [31:0] f);
        logic         sgn;
        logic [7:0]   e;
        logic [W-1:0] mant;
        logic [W-1:0] mag;
        unpack_t      r;
        sgn   = f[31];
        e     = f[30:23];
        mant  = {8'h00, 1'b1, f[22:0]};
        r.err = 1'b0;
        if (e == 8'd0) begin
            mag = 32'h00000000;
        end else if (e >= 8'd128) begin
            mag   = SAT_MAG;
            r.err = 1'b1;
        end else if (e >= 8'd120) begin
            mag = mant << (e - 8'd120);
        end else begin
            mag = mant >> (8'd120 - e);
        end
        if (sgn) begin
            r.value = ~mag + 32'd1;
        end else begin
            r.value = mag;
        end
        return r;
    endfunction

endpackage

// File: rtl/cordic_rot_engine.sv
// One combinational CORDIC micro-rotation (rotation mode), reused every iteration.
// Direction is chosen by comparing the accumulated angle w against the target z.
module cordic_rot_engine
    import cordic_pkg::*;
(
    input  logic [4:0]   iter_i,
    input  logic [W-1:0] atan_i,
    input  logic [W-1:0] x_i,
    input  logic [W-1:0] y_i,
    input  logic [W-1:0] w_i,
    input  logic [W-1:0] z_i,
    output logic [W-1:0] x_o,
    output logic [W-1:0] y_o,
    output logic [W-1:0] w_o
);

    logic signed [W-1:0] x_sh_s;
    logic signed [W-1:0] y_sh_s;
    logic                rot_pos_s;

    assign x_sh_s    = $signed(x_i) >>> iter_i;
    assign y_sh_s    = $signed(y_i) >>> iter_i;
    assign rot_pos_s = ($signed(w_i) < $signed(z_i));

    // Single rotation step; all sums wrap modulo 2^32
    always_comb begin
        x_o = x_i;
        y_o = y_i;
        w_o = w_i;
        if (rot_pos_s) begin
            x_o = x_i - y_sh_s;
            y_o = y_i + x_sh_s;
            w_o = w_i + atan_i;
        end else begin
            x_o = x_i + y_sh_s;
            y_o = y_i - x_sh_s;
            w_o = w_i - atan_i;
        end
    end

endmodule

// File: rtl/cordic_iter_core.sv
// Iterative CORDIC cosine/sine core: float32 angle in, Q2.30 cos/sin out after
// 32 clocked micro-rotations through a single shared rotation engine.
module cordic_iter_core
    import cordic_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [31:0]  angle,
    output logic         busy,
    output logic         done,
    output logic [31:0]  cos_out,
    output logic [31:0]  sin_out,
    output logic         range_err
);

    state_e       state_q, state_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic         rerr_q, rerr_d;
    logic         err_pend_q, err_pend_d;
    logic [W-1:0] cos_q, cos_d;
    logic [W-1:0] sin_q, sin_d;
    logic [W-1:0] x_q, x_d;
    logic [W-1:0] y_q, y_d;
    logic [W-1:0] w_q, w_d;
    logic [W-1:0] z_q, z_d;
    logic [4:0]   iter_q, iter_d;

    unpack_t      unp_s;
    logic [W-1:0] atan_s;
    logic [W-1:0] x_nx_s;
    logic [W-1:0] y_nx_s;
    logic [W-1:0] w_nx_s;

    assign unp_s  = float_to_q230(angle);
    assign atan_s = atan_lut(iter_q);

    cordic_rot_engine u_engine (
        .iter_i (iter_q),
        .atan_i (atan_s),
        .x_i    (x_q),
        .y_i    (y_q),
        .w_i    (w_q),
        .z_i    (z_q),
        .x_o    (x_nx_s),
        .y_o    (y_nx_s),
        .w_o    (w_nx_s)
    );

    // Control FSM and datapath next-state; results only move on the final iteration
    always_comb begin
        state_d    = state_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        rerr_d     = rerr_q;
        err_pend_d = err_pend_q;
        cos_d      = cos_q;
        sin_d      = sin_q;
        x_d        = x_q;
        y_d        = y_q;
        w_d        = w_q;
        z_d        = z_q;
        iter_d     = iter_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    z_d        = unp_s.value;
                    err_pend_d = unp_s.err;
                    x_d        = K_INIT;
                    y_d        = 32'h00000000;
                    w_d        = 32'h00000000;
                    iter_d     = 5'd0;
                    busy_d     = 1'b1;
                    state_d    = ST_RUN;
                end else begin
                    busy_d = 1'b0;
                end
            end
            ST_RUN: begin
                x_d    = x_nx_s;
                y_d    = y_nx_s;
                w_d    = w_nx_s;
                iter_d = iter_q + 5'd1;
                if (iter_q == 5'(ITERS - 1)) begin
                    cos_d   = x_nx_s;
                    sin_d   = y_nx_s;
                    rerr_d  = err_pend_q;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    busy_d = 1'b1;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any run without a done pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rerr_q     <= 1'b0;
            err_pend_q <= 1'b0;
            cos_q      <= 32'h00000000;
            sin_q      <= 32'h00000000;
            x_q        <= 32'h00000000;
            y_q        <= 32'h00000000;
            w_q        <= 32'h00000000;
            z_q        <= 32'h00000000;
            iter_q     <= 5'd0;
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            rerr_q     <= rerr_d;
            err_pend_q <= err_pend_d;
            cos_q      <= cos_d;
            sin_q      <= sin_d;
            x_q        <= x_d;
            y_q        <= y_d;
            w_q        <= w_d;
            z_q        <= z_d;
            iter_q     <= iter_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign cos_out   = cos_q;
    assign sin_out   = sin_q;
    assign range_err = rerr_q;

endmodule

// File: tb/tb_cordic_iter_core.sv
// Directed self-checking bench for cordic_iter_core; expected cos/sin are
// hand-computed real values scaled by 2^30.
module tb_cordic_iter_core;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] angle;
    logic        busy;
    logic        done;
    logic [31:0] cos_out;
    logic [31:0] sin_out;
    logic        range_err;

    int checks;
    int errors;

    localparam int TOL        = 128;
    localparam int Q_ONE      = 1073741824;
    localparam int COS_HALF   = 942297101;
    localparam int SIN_HALF   = 514779252;
    localparam int COS_ONE    = 580145183;
    localparam int SIN_ONE    = 903522590;

    localparam logic [31:0] F_ZERO  = 32'h00000000;
    localparam logic [31:0] F_HALF  = 32'h3F000000;
    localparam logic [31:0] F_MONE  = 32'hBF800000;
    localparam logic [31:0] F_THREE = 32'h40400000;
    localparam logic [31:0] F_INF   = 32'h7F800000;

    cordic_iter_core dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .angle     (angle),
        .busy      (busy),
        .done      (done),
        .cos_out   (cos_out),
        .sin_out   (sin_out),
        .range_err (range_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic longint adiff(input logic [31:0] a, input int b);
        longint d;
        d = longint'($signed(a)) - longint'(b);
        if (d < 0) d = -d;
        return d;
    endfunction

    task automatic launch(input logic [31:0] a);
        angle = a;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (done !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic test_reset;
        rst   = 1'b1;
        start = 1'b0;
        angle = 32'h00000000;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, range_err} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 000", {busy, done, range_err});
        end
        checks++;
        if (cos_out !== 32'h0 || sin_out !== 32'h0) begin
            errors++;
            $display("FAIL reset_data: got %h/%h expected 0/0", cos_out, sin_out);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_zero;
        int lat;
        launch(F_ZERO);
        wait_done(lat);
        checks++;
        if (lat != 32) begin
            errors++;
            $display("FAIL zero_latency: got %0d expected 32", lat);
        end
        checks++;
        if (adiff(cos_out, Q_ONE) > TOL) begin
            errors++;
            $display("FAIL zero_cos: got %h expected ~%h", cos_out, Q_ONE);
        end
        checks++;
        if (adiff(sin_out, 0) > TOL) begin
            errors++;
            $display("FAIL zero_sin: got %h expected ~0", sin_out);
        end
        checks++;
        if (busy !== 1'b0 || range_err !== 1'b0) begin
            errors++;
            $display("FAIL zero_flags: got busy=%b err=%b expected 0 0", busy, range_err);
        end
        @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse_width: got %b expected 0", done);
        end
    endtask

    task automatic test_half;
        int lat;
        launch(F_HALF);
        wait_done(lat);
        checks++;
        if (lat != 32) begin
            errors++;
            $display("FAIL half_latency: got %0d expected 32", lat);
        end
        checks++;
        if (adiff(cos_out, COS_HALF) > TOL || adiff(sin_out, SIN_HALF) > TOL) begin
            errors++;
            $display("FAIL half_cos_sin: got %h/%h expected ~%h/%h", cos_out, sin_out, COS_HALF, SIN_HALF);
        end
        checks++;
        if (range_err !== 1'b0) begin
            errors++;
            $display("FAIL half_range_err: got %b expected 0", range_err);
        end
    endtask

    task automatic test_neg_one;
        int lat;
        launch(F_MONE);
        checks++;
        if (dut.z_q !== 32'hC0000000 || busy !== 1'b1) begin
            errors++;
            $display("FAIL neg_one_unpack: got z=%h busy=%b expected c0000000 1", dut.z_q, busy);
        end
        wait_done(lat);
        checks++;
        if (lat != 32) begin
            errors++;
            $display("FAIL neg_one_latency: got %0d expected 32", lat);
        end
        checks++;
        if (adiff(cos_out, COS_ONE) > TOL || adiff(sin_out, -SIN_ONE) > TOL) begin
            errors++;
            $display("FAIL neg_one_cos_sin: got %h/%h expected ~%h/%h", cos_out, sin_out, COS_ONE, -SIN_ONE);
        end
    endtask

    task automatic test_range;
        int lat;
        launch(F_THREE);
        wait_done(lat);
        checks++;
        if (done !== 1'b1 || range_err !== 1'b1) begin
            errors++;
            $display("FAIL range_three: got done=%b err=%b expected 1 1", done, range_err);
        end
        launch(F_INF);
        wait_done(lat);
        checks++;
        if (done !== 1'b1 || range_err !== 1'b1) begin
            errors++;
            $display("FAIL range_inf: got done=%b err=%b expected 1 1", done, range_err);
        end
        launch(F_MONE);
        wait_done(lat);
        checks++;
        if (range_err !== 1'b0 || adiff(sin_out, -SIN_ONE) > TOL) begin
            errors++;
            $display("FAIL range_clear: got err=%b sin=%h expected 0 ~%h", range_err, sin_out, -SIN_ONE);
        end
    endtask

    task automatic test_start_while_busy;
        int ndone;
        int first_done;
        ndone      = 0;
        first_done = 0;
        launch(F_HALF);
        for (int c = 1; c <= 45; c++) begin
            if (c == 5) begin
                angle = F_MONE;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                ndone++;
                if (first_done == 0) first_done = c;
            end
            if (c == 10) begin
                checks++;
                if (adiff(sin_out, -SIN_ONE) > TOL) begin
                    errors++;
                    $display("FAIL hold_during_run: got %h expected ~%h", sin_out, -SIN_ONE);
                end
            end
        end
        checks++;
        if (ndone != 1 || first_done != 32) begin
            errors++;
            $display("FAIL busy_start_ignored: got %0d dones first at %0d expected 1 at 32", ndone, first_done);
        end
        checks++;
        if (adiff(sin_out, SIN_HALF) > TOL) begin
            errors++;
            $display("FAIL busy_start_result: got %h expected ~%h", sin_out, SIN_HALF);
        end
    endtask

    task automatic test_back_to_back;
        int lat;
        launch(F_ZERO);
        wait_done(lat);
        angle = F_HALF;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_accept: got busy=%b done=%b expected 1 0", busy, done);
        end
        wait_done(lat);
        checks++;
        if (lat != 32 || adiff(cos_out, COS_HALF) > TOL) begin
            errors++;
            $display("FAIL b2b_result: got lat=%0d cos=%h expected 32 ~%h", lat, cos_out, COS_HALF);
        end
    endtask

    task automatic test_reset_mid_run;
        int lat;
        int ndone;
        launch(F_MONE);
        repeat (10) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, range_err} !== 3'b000 || cos_out !== 32'h0 || sin_out !== 32'h0) begin
            errors++;
            $display("FAIL mid_reset_async: got %b %h %h expected 000 0 0", {busy, done, range_err}, cos_out, sin_out);
        end
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) ndone++;
        end
        checks++;
        if (ndone != 0) begin
            errors++;
            $display("FAIL mid_reset_no_done: got %0d dones expected 0", ndone);
        end
        launch(F_HALF);
        wait_done(lat);
        checks++;
        if (lat != 32 || adiff(sin_out, SIN_HALF) > TOL) begin
            errors++;
            $display("FAIL mid_reset_restart: got lat=%0d sin=%h expected 32 ~%h", lat, sin_out, SIN_HALF);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_zero();
        test_half();
        test_neg_one();
        test_range();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
